digit_scan_driver: RTL and testbench

- Time-multiplexed display scanner feeding the BCD segment mux and driving the physical 7-segment digits.
- Produces the mux's 3-bit segment_select and captures the mux's 7-bit led_out pattern into a registered seg_out.
- Drives a one-hot digit enable, with a blanking gap at every digit change to prevent ghosting.
- Sits between the bcd_segment_mux and the chip output pins.

---
 rtl/digit_scan_driver_if.sv | 25 ++
 rtl/digit_scan_driver.sv | 106 ++++++++++
 tb/tb_digit_scan_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/digit_scan_driver_if.sv
// Scan-driver bus: enable and mux pattern in, select/segments/digit enables out.
// DIGIT_SCAN_PWM_EN adds the 3-bit brightness input.
interface digit_scan_driver_if #(
    parameter int NUM_DIGITS = 6
);
    logic                  en;
    logic [6:0]            led_in;
    logic [2:0]            segment_select;
    logic [6:0]            seg_out;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_start;
`ifdef DIGIT_SCAN_PWM_EN
    logic [2:0]            brightness;

    modport master (input en, led_in, brightness,
                    output segment_select, seg_out, digit_en, frame_start);
    modport slave  (output en, led_in, brightness,
                    input segment_select, seg_out, digit_en, frame_start);
`else
    modport master (input en, led_in,
                    output segment_select, seg_out, digit_en, frame_start);
    modport slave  (output en, led_in,
                    input segment_select, seg_out, digit_en, frame_start);
`endif
endinterface

// File: rtl/digit_scan_driver.sv
// Time-multiplexed 7-segment scanner with a blanking gap at each digit change.
// Optional DIGIT_SCAN_PWM_EN shortens the ON window according to brightness.
module digit_scan_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL      = 18,
    parameter int BLANK      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    digit_scan_driver_if.master   bus
);
    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(BLANK - 1);
    localparam logic [2:0]    SEL_LAST = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_BLANK, ST_ON, ST_OFF} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         slot_cnt, slot_nx;
    logic [2:0]            sel, sel_nx;
    logic [6:0]            seg_q, seg_nx;
    logic [NUM_DIGITS-1:0] den_q, den_nx;
    logic [NUM_DIGITS-1:0] onehot;

    assign onehot = NUM_DIGITS'(1) << sel;

`ifdef DIGIT_SCAN_PWM_EN
    localparam int STEP = (DWELL - BLANK) / 8;
    logic [2:0]    bright_q;
    logic [CW-1:0] cnt_off;

    // Brightness latches once per slot so a mid-slot change waits for the next digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           bright_q <= 3'd0;
        else if (slot_cnt == '0) bright_q <= bus.brightness;
    end

    always_comb begin
        cnt_off = CW'(BLANK + (int'(bright_q) + 1) * STEP - 1);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_BLANK;
            slot_cnt <= '0;
            sel      <= '0;
            seg_q    <= '0;
            den_q    <= '0;
        end else begin
            state    <= state_nx;
            slot_cnt <= slot_nx;
            sel      <= sel_nx;
            seg_q    <= seg_nx;
            den_q    <= den_nx;
        end
    end

    always_comb begin
        state_nx = state;
        slot_nx  = slot_cnt + 1'b1;
        sel_nx   = sel;
        seg_nx   = seg_q;
        den_nx   = den_q;
        if (!bus.en) begin
            state_nx = ST_BLANK;
            slot_nx  = '0;
            sel_nx   = '0;
            seg_nx   = '0;
            den_nx   = '0;
        end else if (slot_cnt == CNT_LAST) begin
            // Clearing segments with the digit stops the old pattern bleeding onto the new digit.
            state_nx = ST_BLANK;
            slot_nx  = '0;
            sel_nx   = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
            seg_nx   = '0;
            den_nx   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (slot_cnt == CNT_CAP) begin
                        state_nx = ST_ON;
                        seg_nx   = bus.led_in;
                        den_nx   = onehot;
                    end
                end
                ST_ON: begin
`ifdef DIGIT_SCAN_PWM_EN
                    if (slot_cnt == cnt_off) begin
                        state_nx = ST_OFF;
                        den_nx   = '0;
                    end
`endif
                end
                ST_OFF:  ;
                default: state_nx = ST_BLANK;
            endcase
        end
    end

    assign bus.segment_select = sel;
    assign bus.seg_out        = seg_q;
    assign bus.digit_en       = den_q;
    assign bus.frame_start    = reset_n & bus.en & (sel == 3'd0) & (slot_cnt == '0);
endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: cycle-count reference model, captured patterns scoreboarded in a queue.
// Build with DIGIT_SCAN_PWM_EN defined to also exercise the brightness window.
module tb_digit_scan_driver;
    localparam int N     = 6;
    localparam int DW    = 18;
    localparam int BL    = 2;
    localparam int FRAME = N * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    digit_scan_driver_if #(.NUM_DIGITS(N)) bus();

    digit_scan_driver #(.NUM_DIGITS(N), .DWELL(DW), .BLANK(BL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    logic       fb = 1'b0;
    logic       tog = 1'b0;
    logic [6:0] led_drv = 7'h00;
    assign bus.led_in = fb ? 7'(bus.segment_select + 3'd1) : led_drv;

    int         n_assert = 0;
    int         n_fail = 0;
    int         t = 0;
    logic [6:0] exp_q[$];
    logic [6:0] cur_seg = 7'h00;
    logic [2:0] b_model = 3'd7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_sel"}, 32'(bus.segment_select), 32'd0);
        chk({tag, "_den"}, 32'(bus.digit_en), 32'd0);
        chk({tag, "_seg"}, 32'(bus.seg_out), 32'd0);
        chk({tag, "_fs"},  32'(bus.frame_start), 32'd0);
    endtask

    // One scan cycle with en=1: compare at the falling edge, advance past the next rising edge.
    task automatic cycle();
        int s;
        int sel_e;
        int len;
        logic on_e;
        logic [N-1:0] den_e;
        s     = t % DW;
        sel_e = (t / DW) % N;
        @(negedge clk);
`ifdef DIGIT_SCAN_PWM_EN
        if (s == 0) b_model = bus.brightness;
`endif
        len = ((int'(b_model) + 1) * (DW - BL)) / 8;
        if (s == BL - 1) exp_q.push_back(fb ? 7'(sel_e + 1) : led_drv);
        if (s == BL) begin
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) cur_seg = exp_q.pop_front();
        end
        on_e  = (s >= BL) && (s < BL + len);
        den_e = on_e ? (N'(1) << sel_e) : '0;
        chk("segment_select", 32'(bus.segment_select), 32'(sel_e));
        chk("digit_en",       32'(bus.digit_en), 32'(den_e));
        chk("seg_out",        32'(bus.seg_out), (s >= BL) ? 32'(cur_seg) : 32'd0);
        chk("frame_start",    32'(bus.frame_start), 32'((t % FRAME) == 0));
        chk("onehot0",        32'($onehot0(bus.digit_en)), 32'd1);
        if (tog && s == 10) led_drv = ~led_drv;
        @(posedge clk);
        #1;
        t++;
    endtask

    initial begin
        bus.en = 1'b0;
`ifdef DIGIT_SCAN_PWM_EN
        bus.brightness = 3'd7;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_dark("reset");

        // First slot with a fixed pattern, then into digit 1's blanking
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.en  = 1'b1;
        led_drv = 7'h5A;
        t = 0;
        repeat (19) cycle();

        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk_dark("en_low");
        exp_q.delete();

        // Two full frames with the pattern fed back from segment_select
        fb = 1'b1;
        bus.en = 1'b1;
        t = 0;
        repeat (2 * FRAME + 1) cycle();

        // led_in toggles mid-window; seg_out must keep the value captured at blank end
        fb = 1'b0;
        led_drv = 7'h33;
        tog = 1'b1;
        repeat (36) cycle();
        tog = 1'b0;

        while ((t % FRAME) != 3 * DW + 12) cycle();
        bus.en = 1'b0;
        @(negedge clk);
        chk("en_drop_same_cycle", 32'(bus.digit_en), 32'(N'(1) << 3));
        @(posedge clk);
        #1;
        chk_dark("en_drop");
        repeat (4) begin
            @(posedge clk);
            #1;
            chk_dark("en_idle");
        end
        exp_q.delete();

        bus.en = 1'b1;
        fb = 1'b1;
        t = 0;
        repeat (24) cycle();

        // Async reset between edges while a digit is lit
        while ((t % DW) != 5) cycle();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_dark("async_reset");
        @(posedge clk);
        #1;
        chk_dark("in_reset");
        reset_n = 1'b1;
        exp_q.delete();
        t = 0;
        repeat (22) cycle();

`ifdef DIGIT_SCAN_PWM_EN
        bus.brightness = 3'd3;
        repeat (32) cycle();
        while ((t % DW) != 5) cycle();
        bus.brightness = 3'd0;
        repeat (36) cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
